// File: rtl/soc_pio_ext_if.sv
// Avalon-MM slave bus bundle for the PIO peripheral: word address, select,
// active-low write strobe, 32-bit write data and zero-latency read data.
interface soc_pio_ext_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/soc_pio_ext.sv
// Parametrised PIO peripheral: output register with atomic set/clear,
// synchronised inputs with per-bit edge capture (W1C) and a maskable
// level interrupt. Zero-wait-state slave, reads are combinational.
module soc_pio_ext #(
    parameter int                   OUT_WIDTH = 16,
    parameter int                   IN_WIDTH  = 4,
    parameter logic [OUT_WIDTH-1:0] OUT_RESET = '0,
    parameter int                   EDGE_TYPE = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    soc_pio_ext_if.slave         bus,
    input  logic [IN_WIDTH-1:0]  in_port,
    output logic [OUT_WIDTH-1:0] out_port,
    output logic                 irq
);

    logic                 wr;
    logic [OUT_WIDTH-1:0] wdata_out;
    logic [IN_WIDTH-1:0]  wdata_in;
    logic                 unused_wdata;

    logic [OUT_WIDTH-1:0] data_out_q, data_out_d;
    logic [IN_WIDTH-1:0]  irqmask_q, irqmask_d;
    logic [IN_WIDTH-1:0]  edgecap_q, edgecap_d;
    logic [IN_WIDTH-1:0]  clr_mask;
    logic [IN_WIDTH-1:0]  in_meta_q, in_sync_q, in_prev_q;
    logic [IN_WIDTH-1:0]  edge_vec;
    logic [31:0]          readdata_c;

    assign wr        = bus.chipselect & ~bus.write_n;
    // Write data above each register's width is simply dropped.
    assign wdata_out = bus.writedata[OUT_WIDTH-1:0];
    assign wdata_in  = bus.writedata[IN_WIDTH-1:0];
    assign unused_wdata = ^bus.writedata;

    // Per-bit edge detector on the synchronised input; the edge sense is fixed at build time.
    for (genvar gi = 0; gi < IN_WIDTH; gi++) begin : g_edge
        if (EDGE_TYPE == 0) begin : g_rise
            assign edge_vec[gi] = in_sync_q[gi] & ~in_prev_q[gi];
        end else if (EDGE_TYPE == 1) begin : g_fall
            assign edge_vec[gi] = ~in_sync_q[gi] & in_prev_q[gi];
        end else begin : g_any
            assign edge_vec[gi] = in_sync_q[gi] ^ in_prev_q[gi];
        end
    end

    // Register write decode; a fresh edge overrides a same-cycle W1C of that bit.
    always_comb begin
        data_out_d = data_out_q;
        irqmask_d  = irqmask_q;
        clr_mask   = '0;
        if (wr) begin
            case (bus.address)
                3'd0:    data_out_d = wdata_out;
                3'd2:    irqmask_d  = wdata_in;
                3'd3:    clr_mask   = wdata_in;
                3'd4:    data_out_d = data_out_q | wdata_out;
                3'd5:    data_out_d = data_out_q & ~wdata_out;
                default: ;
            endcase
        end
        edgecap_d = (edgecap_q & ~clr_mask) | edge_vec;
    end

    // Read mux, zero-extended to the bus width; reads have no side effects.
    always_comb begin
        readdata_c = '0;
        case (bus.address)
            3'd0:    readdata_c[IN_WIDTH-1:0]  = in_sync_q;
            3'd1:    readdata_c[OUT_WIDTH-1:0] = data_out_q;
            3'd2:    readdata_c[IN_WIDTH-1:0]  = irqmask_q;
            3'd3:    readdata_c[IN_WIDTH-1:0]  = edgecap_q;
            default: ;
        endcase
    end

    assign bus.readdata = readdata_c;

    // Software-visible registers; reset clears pending captures immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out_q <= OUT_RESET;
            irqmask_q  <= '0;
            edgecap_q  <= '0;
        end else begin
            data_out_q <= data_out_d;
            irqmask_q  <= irqmask_d;
            edgecap_q  <= edgecap_d;
        end
    end

    // Two-flop synchroniser plus a history flop for edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_meta_q <= '0;
            in_sync_q <= '0;
            in_prev_q <= '0;
        end else begin
            in_meta_q <= in_port;
            in_sync_q <= in_meta_q;
            in_prev_q <= in_sync_q;
        end
    end

    assign out_port = data_out_q;
    assign irq      = |(edgecap_q & irqmask_q);

endmodule

// File: tb/tb_soc_pio_ext.sv
// Testbench for soc_pio_ext: a table of register-access vectors followed by
// hand-written sequences for edge capture, W1C/edge collision, the three
// edge senses and asynchronous reset. Expected results go through a queue.
module tb_soc_pio_ext;

    logic        clk;
    logic        reset;
    logic [3:0]  in_port;
    logic [3:0]  in_port_b;
    logic [15:0] out0, out1, out2;
    logic        irq0, irq1, irq2;

    soc_pio_ext_if b0 ();
    soc_pio_ext_if b1 ();
    soc_pio_ext_if b2 ();

    // All three instances see the same bus writes; only read data differs.
    assign b1.address    = b0.address;
    assign b1.chipselect = b0.chipselect;
    assign b1.write_n    = b0.write_n;
    assign b1.writedata  = b0.writedata;
    assign b2.address    = b0.address;
    assign b2.chipselect = b0.chipselect;
    assign b2.write_n    = b0.write_n;
    assign b2.writedata  = b0.writedata;

    soc_pio_ext #(.OUT_WIDTH(16), .IN_WIDTH(4), .OUT_RESET(16'hA5A5), .EDGE_TYPE(0)) dut0 (
        .clk(clk), .reset(reset), .bus(b0), .in_port(in_port), .out_port(out0), .irq(irq0));
    soc_pio_ext #(.OUT_WIDTH(16), .IN_WIDTH(4), .OUT_RESET(16'hA5A5), .EDGE_TYPE(1)) dut1 (
        .clk(clk), .reset(reset), .bus(b1), .in_port(in_port_b), .out_port(out1), .irq(irq1));
    soc_pio_ext #(.OUT_WIDTH(16), .IN_WIDTH(4), .OUT_RESET(16'hA5A5), .EDGE_TYPE(2)) dut2 (
        .clk(clk), .reset(reset), .bus(b2), .in_port(in_port_b), .out_port(out2), .irq(irq2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int          dut;
        logic [2:0]  addr;
        logic [31:0] exp_rd;
        logic [15:0] exp_out;
        logic        exp_irq;
    } sb_t;

    typedef struct {
        string       name;
        bit          do_wr;
        logic [2:0]  waddr;
        logic [31:0] wdata;
        logic [2:0]  raddr;
        logic [31:0] exp_rd;
        logic [15:0] exp_out;
    } vec_t;

    sb_t         sb_q[$];
    vec_t        vq[$];
    int          checks;
    int          failures;
    logic [15:0] cur_out;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_write(input logic [2:0] addr, input logic [31:0] data);
        b0.address    = addr;
        b0.writedata  = data;
        b0.chipselect = 1'b1;
        b0.write_n    = 1'b0;
        @(negedge clk);
        b0.chipselect = 1'b0;
        b0.write_n    = 1'b1;
        b0.writedata  = '0;
    endtask

    task automatic sb_push(input string name, input int dut, input logic [2:0] addr,
                           input logic [31:0] exp_rd, input logic exp_irq);
        sb_t e;
        e.name = name; e.dut = dut; e.addr = addr;
        e.exp_rd = exp_rd; e.exp_out = cur_out; e.exp_irq = exp_irq;
        sb_q.push_back(e);
    endtask

    // Pop every pending expectation, probe the addressed instance and compare.
    task automatic sb_check();
        sb_t         e;
        logic [31:0] rd;
        logic [15:0] op;
        logic        iq;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            b0.address    = e.addr;
            b0.chipselect = 1'b1;
            b0.write_n    = 1'b1;
            #1;
            case (e.dut)
                1:       begin rd = b1.readdata; op = out1; iq = irq1; end
                2:       begin rd = b2.readdata; op = out2; iq = irq2; end
                default: begin rd = b0.readdata; op = out0; iq = irq0; end
            endcase
            b0.chipselect = 1'b0;
            checks++;
            if (rd !== e.exp_rd) begin
                failures++;
                $display("FAIL %s dut%0d readdata[a%0d] got %h want %h", e.name, e.dut, e.addr, rd, e.exp_rd);
            end
            checks++;
            if (op !== e.exp_out) begin
                failures++;
                $display("FAIL %s dut%0d out_port got %h want %h", e.name, e.dut, op, e.exp_out);
            end
            checks++;
            if (iq !== e.exp_irq) begin
                failures++;
                $display("FAIL %s dut%0d irq got %b want %b", e.name, e.dut, iq, e.exp_irq);
            end
            $display("txn %-14s dut%0d addr=%0d rd=%h out=%h irq=%b", e.name, e.dut, e.addr, rd, op, iq);
        end
    endtask

    initial begin
        checks = 0; failures = 0;
        reset = 1'b1;
        in_port = '0; in_port_b = '0;
        b0.address = '0; b0.chipselect = 1'b0; b0.write_n = 1'b1; b0.writedata = '0;

        //            name            wr   wa    wdata          ra    exp_rd         exp_out
        vq.push_back('{"rst_outval",  0, 3'd0, 32'h0,         3'd1, 32'h0000A5A5, 16'hA5A5});
        vq.push_back('{"rst_edgecap", 0, 3'd0, 32'h0,         3'd3, 32'h0,        16'hA5A5});
        vq.push_back('{"rst_mask",    0, 3'd0, 32'h0,         3'd2, 32'h0,        16'hA5A5});
        vq.push_back('{"data_wr",     1, 3'd0, 32'h1234FFFF,  3'd1, 32'h0000FFFF, 16'hFFFF});
        vq.push_back('{"outset",      1, 3'd4, 32'h0000000F,  3'd1, 32'h0000FFFF, 16'hFFFF});
        vq.push_back('{"outclr",      1, 3'd5, 32'h00000030,  3'd1, 32'h0000FFCF, 16'hFFCF});
        vq.push_back('{"outset_rd",   0, 3'd0, 32'h0,         3'd4, 32'h0,        16'hFFCF});
        vq.push_back('{"outclr_rd",   0, 3'd0, 32'h0,         3'd5, 32'h0,        16'hFFCF});
        vq.push_back('{"outval_ro",   1, 3'd1, 32'h00000000,  3'd1, 32'h0000FFCF, 16'hFFCF});
        vq.push_back('{"hole6",       1, 3'd6, 32'hFFFFFFFF,  3'd6, 32'h0,        16'hFFCF});
        vq.push_back('{"hole7",       1, 3'd7, 32'hFFFFFFFF,  3'd7, 32'h0,        16'hFFCF});
        vq.push_back('{"irqmask",     1, 3'd2, 32'hFFFFFFF2,  3'd2, 32'h00000002, 16'hFFCF});
        vq.push_back('{"data_rd",     0, 3'd0, 32'h0,         3'd0, 32'h0,        16'hFFCF});
        vq.push_back('{"outset_hi",   1, 3'd4, 32'hFFFF0000,  3'd1, 32'h0000FFCF, 16'hFFCF});
        vq.push_back('{"outclr_many", 1, 3'd5, 32'h0000FFC0,  3'd1, 32'h0000000F, 16'h000F});
        vq.push_back('{"outset_mid",  1, 3'd4, 32'h0000A500,  3'd1, 32'h0000A50F, 16'hA50F});

        step(2);
        // Reset state is probed while reset is still asserted.
        cur_out = 16'hA5A5;
        sb_push("in_reset", 0, 3'd1, 32'h0000A5A5, 1'b0);
        sb_check();
        step(1);
        reset = 1'b0;
        step(1);

        for (int i = 0; i < vq.size(); i++) begin
            if (vq[i].do_wr) do_write(vq[i].waddr, vq[i].wdata);
            cur_out = vq[i].exp_out;
            sb_push(vq[i].name, 0, vq[i].raddr, vq[i].exp_rd, 1'b0);
            sb_check();
        end
        cur_out = 16'hA50F;
        step(1);

        // Rising edge on bit1 (unmasked): capture and irq two edges after sampling.
        in_port = 4'b0010;
        step(1);
        sb_push("lat_meta", 0, 3'd0, 32'h0, 1'b0);
        sb_push("lat_cap0", 0, 3'd3, 32'h0, 1'b0);
        sb_check();
        step(1);
        sb_push("lat_sync", 0, 3'd0, 32'h2, 1'b0);
        sb_push("lat_cap1", 0, 3'd3, 32'h0, 1'b0);
        sb_check();
        step(1);
        sb_push("lat_cap2", 0, 3'd3, 32'h2, 1'b1);
        sb_check();

        // Bit0 edge is masked; clearing bit1 drops irq right after the write.
        in_port = 4'b0011;
        step(3);
        sb_push("bit0_cap", 0, 3'd3, 32'h3, 1'b1);
        sb_check();
        do_write(3'd3, 32'h2);
        sb_push("w1c_bit1", 0, 3'd3, 32'h1, 1'b0);
        sb_check();

        // Falling edge is ignored by the rising detector.
        in_port = 4'b0001;
        step(3);
        sb_push("fall_ignored", 0, 3'd3, 32'h1, 1'b0);
        sb_check();
        in_port = 4'b0011;
        step(3);
        sb_push("rise_again", 0, 3'd3, 32'h3, 1'b1);
        sb_check();
        in_port = 4'b0001;
        step(3);
        // New rise reaches the detector exactly when the W1C is written.
        in_port = 4'b0011;
        step(2);
        do_write(3'd3, 32'h2);
        sb_push("collision", 0, 3'd3, 32'h3, 1'b1);
        sb_check();
        do_write(3'd3, 32'h2);
        sb_push("w1c_after", 0, 3'd3, 32'h1, 1'b0);
        sb_check();

        // Edge senses: falling-only (dut1) and any-edge (dut2) on a 3-cycle pulse.
        do_write(3'd3, 32'hF);
        in_port_b = 4'b0100;
        step(3);
        sb_push("any_rise", 2, 3'd3, 32'h4, 1'b0);
        sb_push("fall_rise", 1, 3'd3, 32'h0, 1'b0);
        sb_check();
        in_port_b = 4'b0000;
        do_write(3'd3, 32'h4);
        sb_push("any_clr", 2, 3'd3, 32'h0, 1'b0);
        sb_push("fall_wait", 1, 3'd3, 32'h0, 1'b0);
        sb_check();
        step(2);
        sb_push("any_fall", 2, 3'd3, 32'h4, 1'b0);
        sb_push("fall_fall", 1, 3'd3, 32'h4, 1'b0);
        sb_check();

        // Fill every capture bit with irq enabled, then reset between clock edges.
        do_write(3'd2, 32'hF);
        in_port = 4'b0000;
        step(3);
        in_port = 4'b1111;
        step(3);
        sb_push("cap_full", 0, 3'd3, 32'hF, 1'b1);
        sb_check();
        step(1);
        #2;
        reset = 1'b1;
        cur_out = 16'hA5A5;
        sb_push("async_cap", 0, 3'd3, 32'h0, 1'b0);
        sb_push("async_out", 0, 3'd1, 32'h0000A5A5, 1'b0);
        sb_check();
        step(2);

        // Input held high through reset yields exactly one rising edge.
        reset = 1'b0;
        step(1);
        sb_push("post_meta", 0, 3'd0, 32'h0, 1'b0);
        sb_check();
        step(1);
        sb_push("post_sync", 0, 3'd0, 32'hF, 1'b0);
        sb_push("post_nocap", 0, 3'd3, 32'h0, 1'b0);
        sb_check();
        step(1);
        sb_push("post_edge", 0, 3'd3, 32'hF, 1'b0);
        sb_check();
        do_write(3'd3, 32'hF);
        step(2);
        sb_push("post_once", 0, 3'd3, 32'h0, 1'b0);
        sb_check();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/soc_pio_ext.md
# soc_pio_ext

Parametrised Avalon-MM PIO peripheral for the Nios II SoC. It replaces the fixed-width, write-only output PIO with three parts: a configurable-width output register with atomic set/clear access, a synchronised input port with per-bit edge capture, and a maskable level interrupt. It sits on the system interconnect as a zero-wait-state slave and drives board-level signals such as hex digits, LEDs, switches and keys.

## Interface
Parameters:
- OUT_WIDTH, 16: width of out_port, 1..32
- IN_WIDTH, 4: width of in_port, 1..32
- OUT_RESET, 0: reset value of the output register, OUT_WIDTH bits
- EDGE_TYPE, 0: edge that sets capture bits; 0 rising, 1 falling, 2 any

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- address  in  3  word address
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  32  write data
- readdata  out  32  read data, combinational from address
- in_port  in  IN_WIDTH  asynchronous external inputs
- out_port  out  OUT_WIDTH  registered outputs
- irq  out  1  level interrupt, active-high

## Operation
- Write strobe: wr = chipselect & ~write_n. Reads have no side effects.
- Register map, by word address:
  - 0 DATA. Read returns in_sync, zero-extended. Write loads data_out with writedata[OUT_WIDTH-1:0].
  - 1 OUTVAL. Read returns data_out, zero-extended. Write is ignored.
  - 2 IRQMASK. Read/write, IN_WIDTH bits.
  - 3 EDGECAP. Read returns capture bits. Writing 1 to a bit clears that bit; writing 0 leaves it unchanged.
  - 4 OUTSET. Write sets data_out |= writedata. Read returns 0.
  - 5 OUTCLR. Write clears data_out &= ~writedata. Read returns 0.
  - 6, 7: reads return 0, writes are ignored.
- Unused upper bits read as 0. Write data bits above the register width are discarded.
- Input path:
  - Two-flop synchroniser: in_meta, then in_sync.
  - A third flop holds in_prev.
  - Edge vector per EDGE_TYPE:
    - rising: in_sync & ~in_prev
    - falling: ~in_sync & in_prev
    - any: in_sync ^ in_prev
- EDGECAP next value = (edgecap & ~clr_mask) | edge. clr_mask is writedata masked by (wr & address==3).
- If a new edge and a W1C of the same bit occur in the same cycle, the edge wins and the bit stays 1.
- irq = |(edgecap & irqmask), combinational from registers.
- out_port = data_out directly, with no output logic.

## Timing
- Reset (async assert, sync deassert handled externally):
  - data_out = OUT_RESET
  - irqmask = 0, edgecap = 0
  - in_meta, in_sync, in_prev = 0
  - irq = 0, out_port = OUT_RESET
- Because in_prev resets to 0, an input held at 1 through reset produces one rising edge 2 cycles after reset release. This is intended and verified.
- Write latency: a register write at clock edge k is visible on out_port and readdata after edge k.
- Read latency 0: readdata is valid in the same cycle as address and chipselect. The interconnect is configured for readLatency 0.
- Input latency:
  - in_port change sampled at edge k gives in_sync at edge k+1.
  - edgecap bit and irq are set after edge k+2.
- The input must be stable for at least 1 clock to be captured. Pulses shorter than that may be missed.
- W1C of edgecap at edge k drops irq after edge k, unless a new edge occurs at that same edge.
- A reset asserted mid-operation clears everything immediately, including pending edgecap bits. No write in progress completes.

## Test plan
- Reset with OUT_WIDTH=16, OUT_RESET=16'hA5A5 -> out_port=A5A5, irq=0, read addr 1 = 0000A5A5, read addr 3 = 0.
- Write 0x1234_FFFF to addr 0, then OUTSET 0x000F, then OUTCLR 0x0030 -> out_port reads FFFF, FFFF, then FFCF. Upper bits are discarded.
- EDGE_TYPE=0, IN_WIDTH=4, irqmask=4'b0010; in_port bit1 goes 0->1 at edge k -> edgecap=4'b0010 and irq=1 after edge k+2. A bit0 edge sets edgecap bit0 but irq is unaffected by it.
- Write 1 to addr 3 bit1 in the same cycle a new rising edge on bit1 reaches the edge detector -> bit1 stays 1 and irq stays 1. The next W1C without an edge clears bit1 and drops irq the cycle after.
- EDGE_TYPE=2: in_port bit2 pulses high for 3 cycles -> edgecap bit2 is set by the rise. Clear it, and the fall sets it again. With EDGE_TYPE=1, only the fall sets it.
- Assert reset while edgecap=4'hF and irq=1 -> edgecap=0, irq=0, and out_port=OUT_RESET immediately, with no clock edge needed.
